// File: rtl/regfile_clr_if.sv
// Register-file access bus: decode-side read request/response and
// writeback-side write request, plus busy/err status back to the pipeline.
//   master (pipeline) : drives ren, rs1, rs2, wen, rd, rd_val
//                       receives busy, rs1_val, rs2_val, err
//   slave  (regfile)  : the mirror image
interface regfile_clr_if #(
   parameter int unsigned W = 32
);
   localparam int unsigned IDX_W = 5;

   logic             busy;
   logic             ren;
   logic [IDX_W-1:0] rs1;
   logic [IDX_W-1:0] rs2;
   logic [W-1:0]     rs1_val;
   logic [W-1:0]     rs2_val;
   logic             wen;
   logic [IDX_W-1:0] rd;
   logic [W-1:0]     rd_val;
   logic             err;

   modport master (
      input  busy, rs1_val, rs2_val, err,
      output ren, rs1, rs2, wen, rd, rd_val
   );

   modport slave (
      output busy, rs1_val, rs2_val, err,
      input  ren, rs1, rs2, wen, rd, rd_val
   );
endinterface

// File: rtl/regfile_clr.sv
// Dual-read / single-write integer register file with sequential hardware
// clear after synchronous reset, optional write-to-read bypass and an
// out-of-range index flag. Every output is registered.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset; restarts the clear sequence
//   bus  - regfile_clr_if.slave: busy, ren/rs1/rs2 -> rs1_val/rs2_val,
//          wen/rd/rd_val, err
// Parameters: W data width, NREGS 16 or 32, BYPASS 0 (read-before-write)
//             or 1 (read returns the value written in the same cycle).
module regfile_clr #(
   parameter int unsigned W      = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned BYPASS = 0
) (
   input  logic         clk,
   input  logic         rst,
   regfile_clr_if.slave bus
);
   localparam int unsigned IDX_W  = 5;
   localparam int unsigned AW     = (NREGS == 16) ? 4 : 5;
   localparam logic        OOR_EN = (NREGS == 16);
   localparam logic        BYP_EN = (BYPASS != 0);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NREGS - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_cnt;
   logic [IDX_W-1:0] w_cnt_nxt;
   logic             r_busy;
   logic             r_err;
   logic [W-1:0]     r_rs1_val;
   logic [W-1:0]     r_rs2_val;

   // One storage copy per read port, always written together
   logic [W-1:0]     r_mem1 [NREGS];
   logic [W-1:0]     r_mem2 [NREGS];

   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic [W-1:0]     w_wdata;

   logic             w_rs1_oor;
   logic             w_rs2_oor;
   logic             w_rd_oor;
   logic             w_wr_legal;
   logic             w_rd_en;
   logic             w_err_nxt;
   logic [W-1:0]     w_rs1_data;
   logic [W-1:0]     w_rs2_data;

   // Out-of-range exists only in the 16-entry build (index bit 4 set)
   assign w_rs1_oor  = OOR_EN & bus.rs1[4];
   assign w_rs2_oor  = OOR_EN & bus.rs2[4];
   assign w_rd_oor   = OOR_EN & bus.rd[4];
   assign w_wr_legal = bus.wen & (bus.rd != '0) & ~w_rd_oor;

   assign w_rd_en   = (r_state == RUN) & bus.ren;
   assign w_err_nxt = (r_state == RUN) &
                      ((bus.ren & (w_rs1_oor | w_rs2_oor)) | (bus.wen & w_rd_oor));

   // Read data select: x0 and out-of-range read as 0, bypass never applies to x0
   always_comb begin
      w_rs1_data = r_mem1[bus.rs1[AW-1:0]];
      if (BYP_EN && w_wr_legal && (bus.rd == bus.rs1)) w_rs1_data = bus.rd_val;
      if ((bus.rs1 == '0) || w_rs1_oor)                 w_rs1_data = '0;
   end

   always_comb begin
      w_rs2_data = r_mem2[bus.rs2[AW-1:0]];
      if (BYP_EN && w_wr_legal && (bus.rd == bus.rs2)) w_rs2_data = bus.rd_val;
      if ((bus.rs2 == '0) || w_rs2_oor)                 w_rs2_data = '0;
   end

   // Next state and write-port control; CLEAR sweeps zeros through every entry
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_we        = 1'b0;
      w_waddr     = bus.rd[AW-1:0];
      w_wdata     = bus.rd_val;
      unique case (r_state)
         CLEAR: begin
            w_we      = 1'b1;
            w_waddr   = r_cnt[AW-1:0];
            w_wdata   = '0;
            w_cnt_nxt = r_cnt + IDX_W'(1);
            if (r_cnt == LAST) w_state_nxt = RUN;
         end
         RUN: begin
            w_we = w_wr_legal;
         end
         default: begin
            w_state_nxt = CLEAR;
         end
      endcase
      // Nothing is written on an edge where reset is sampled
      if (rst) w_we = 1'b0;
   end

   // State, counter and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= CLEAR;
         r_cnt     <= '0;
         r_busy    <= 1'b1;
         r_err     <= 1'b0;
         r_rs1_val <= '0;
         r_rs2_val <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_state_nxt == CLEAR);
         r_err   <= w_err_nxt;
         if (w_rd_en) begin
            r_rs1_val <= w_rs1_data;
            r_rs2_val <= w_rs2_data;
         end
      end
   end

   // Storage; no reset so it can map onto block RAM
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem1[w_waddr] <= w_wdata;
         r_mem2[w_waddr] <= w_wdata;
      end
   end

   assign bus.busy    = r_busy;
   assign bus.err     = r_err;
   assign bus.rs1_val = r_rs1_val;
   assign bus.rs2_val = r_rs2_val;
endmodule
